// File: rtl/vec_operand_select.sv
// Operand-fetch/forwarding selector: each lane picks one of NSRC vector sources
// (global, per-lane or broadcast select, masked), held in one valid/ready stage.

module vec_operand_select_lane #(
  parameter int W    = 32,
  parameter int NSRC = 4,
  parameter int SELW = 2
) (
  input  logic [NSRC-1:0][W-1:0] cand,
  input  logic [SELW-1:0]        idx,
  input  logic                   act,
  output logic [W-1:0]           data,
  output logic                   bad
);
  localparam logic [SELW:0] LIMIT = (SELW+1)'(NSRC);

  // Out-of-range is reported even on masked lanes; data stays zero either way.
  assign bad = {1'b0, idx} >= LIMIT;

  always_comb begin
    data = '0;
    for (int s = 0; s < NSRC; s++)
      if (act && idx == SELW'(s)) data = cand[s];
  end
endmodule

module vec_operand_select #(
  parameter  int LANES = 4,
  parameter  int W     = 32,
  parameter  int NSRC  = 4,
  parameter  int CNTW  = 16,
  localparam int SELW  = $clog2(NSRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSRC*LANES*W-1:0] src,
  input  logic [SELW-1:0]         sel,
  input  logic                    lane_sel_en,
  input  logic [LANES*SELW-1:0]   lane_sel,
  input  logic                    bcast,
  input  logic [LANES-1:0]        mask,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*W-1:0]      out_data,
  output logic [LANES-1:0]        out_mask,
  output logic                    sel_err,
  output logic [CNTW-1:0]         xfer_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [LANES-1:0]        mask;
    logic [LANES-1:0][W-1:0] data;
  } beat_t;

  logic [LANES-1:0][NSRC-1:0][W-1:0] cand;
  logic [LANES-1:0][SELW-1:0]        idx;
  logic [LANES-1:0][W-1:0]           lane_data;
  logic [LANES-1:0]                  lane_bad;

  state_t state;
  beat_t  beat_q;
  beat_t  beat_d;
  logic   accept;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Broadcast feeds every lane from lane 0 of each source.
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      assign cand[l][s] = bcast ? src[s*LANES*W +: W] : src[(s*LANES+l)*W +: W];
    end

    assign idx[l] = (!bcast && lane_sel_en) ? lane_sel[l*SELW +: SELW] : sel;

    vec_operand_select_lane #(.W(W), .NSRC(NSRC), .SELW(SELW)) u_lane (
      .cand (cand[l]),
      .idx  (idx[l]),
      .act  (mask[l]),
      .data (lane_data[l]),
      .bad  (lane_bad[l])
    );
  end

  assign beat_d.mask = mask;
  assign beat_d.data = lane_data;

  assign in_ready  = !flush && (state == EMPTY || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);
  assign out_data  = beat_q.data;
  assign out_mask  = beat_q.mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      beat_q   <= '0;
      sel_err  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (accept) begin
        state    <= FULL;
        beat_q   <= beat_d;
        xfer_cnt <= xfer_cnt + CNTW'(1);
      end else if (flush || out_ready) begin
        state <= EMPTY;
      end

      // Set wins over clear when both land in the same cycle.
      if (accept && |lane_bad) sel_err <= 1'b1;
      else if (clr_err)        sel_err <= 1'b0;
    end
  end
endmodule
